// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the multiply/divide issue unit.
//   - one-hot bit positions of req_op and the matching one-hot masks
//   - state encoding of the issue FSM
//   - operation codes driven to the multiplier and the divider
//   - md_decode(): classifies a request opcode (anything not exactly one-hot is a no-op)
package md_pkg;

  localparam int OP_MULT  = 0;
  localparam int OP_MULTU = 1;
  localparam int OP_DIV   = 2;
  localparam int OP_DIVU  = 3;
  localparam int OP_MTHI  = 4;
  localparam int OP_MTLO  = 5;

  localparam logic [5:0] OH_MULT  = 6'b000001 << OP_MULT;
  localparam logic [5:0] OH_MULTU = 6'b000001 << OP_MULTU;
  localparam logic [5:0] OH_DIV   = 6'b000001 << OP_DIV;
  localparam logic [5:0] OH_DIVU  = 6'b000001 << OP_DIVU;
  localparam logic [5:0] OH_MTHI  = 6'b000001 << OP_MTHI;
  localparam logic [5:0] OH_MTLO  = 6'b000001 << OP_MTLO;

  // {unsigned, signed} op codes understood by multiplier and divider
  localparam logic [1:0] MD_MUL_SGN  = 2'b01;
  localparam logic [1:0] MD_MUL_USGN = 2'b10;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_DIV_WAIT = 2'd1;
  localparam logic [1:0] ST_DRAIN    = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE     = ST_IDLE,
    S_DIV_WAIT = ST_DIV_WAIT,
    S_DRAIN    = ST_DRAIN
  } md_state_e;

  typedef enum logic [2:0] {
    K_NONE  = 3'd0,
    K_MULT  = 3'd1,
    K_MULTU = 3'd2,
    K_DIV   = 3'd3,
    K_DIVU  = 3'd4,
    K_MTHI  = 3'd5,
    K_MTLO  = 3'd6
  } md_kind_e;

  function automatic md_kind_e md_decode(input logic [5:0] op);
    md_kind_e k;
    case (op)
      OH_MULT:  k = K_MULT;
      OH_MULTU: k = K_MULTU;
      OH_DIV:   k = K_DIV;
      OH_DIVU:  k = K_DIVU;
      OH_MTHI:  k = K_MTHI;
      OH_MTLO:  k = K_MTLO;
      default:  k = K_NONE;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/md_hilo_reg.sv
// md_hilo_reg: architectural HI/LO registers with independent write enables.
// Ports:
//   clk, resetn          clock, asynchronous active-low reset (HI=LO=0)
//   hi_we, lo_we         write enables
//   hi_wdata, lo_wdata   write data
//   hi, lo               read values
// Build option MD_HILO_BYPASS_EN: when defined, hi/lo forward the data being
// written in the same cycle; otherwise they are the register outputs only.
module md_hilo_reg (
  input  logic        clk,
  input  logic        resetn,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] hi_wdata,
  input  logic [31:0] lo_wdata,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  logic [31:0] hi_q;
  logic [31:0] lo_q;

  // HI/LO storage
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_q <= 32'h0;
      lo_q <= 32'h0;
    end else begin
      if (hi_we) hi_q <= hi_wdata;
      if (lo_we) lo_q <= lo_wdata;
    end
  end

`ifdef MD_HILO_BYPASS_EN
  assign hi = hi_we ? hi_wdata : hi_q;
  assign lo = lo_we ? lo_wdata : lo_q;
`else
  assign hi = hi_q;
  assign lo = lo_q;
`endif

endmodule

// File: rtl/md_unit.sv
// md_unit: multiply/divide issue unit of the execute stage.
// Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from ES, drives the combinational
// multiplier or the handshaked divider and retires results into HI/LO.
// Ports:
//   clk, resetn                    clock, asynchronous active-low reset
//   req_valid/req_ready/req_op     request handshake, one-hot op (bit0 = MULT)
//   req_src1, req_src2             operands (MTHI/MTLO use src1)
//   flush                          cancels the accepted or in-flight op
//   busy, done, hi, lo             status and HI/LO read values
//   mul_op, mul_src1/2, mul_result multiplier interface
//   div_op, dividend, divisor,
//   div_in_valid, div_result,
//   div_out_valid, div_out_ready   divider interface
//   div_err                        sticky divide timeout flag
// Parameter DIV_TIMEOUT: cycles in DIV_WAIT/DRAIN before div_err (0 = off).
// Build option MD_HILO_BYPASS_EN: forward written HI/LO values in the retire
// cycle and drop busy in the completion cycle; otherwise busy is held one
// extra cycle after every write.
module md_unit
  import md_pkg::*;
#(
  parameter int DIV_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_op,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [1:0]  mul_op,
  output logic [31:0] mul_src1,
  output logic [31:0] mul_src2,
  input  logic [63:0] mul_result,
  output logic [1:0]  div_op,
  output logic [31:0] dividend,
  output logic [31:0] divisor,
  output logic        div_in_valid,
  input  logic [63:0] div_result,
  input  logic        div_out_valid,
  output logic        div_out_ready,
  output logic        div_err
);

  md_state_e   state;
  md_kind_e    kind;
  logic        accept;
  logic        div_ret;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] hi_wdata;
  logic [31:0] lo_wdata;
  logic [31:0] wait_cnt;

  assign kind      = md_decode(req_op);
  assign req_ready = (state == S_IDLE);
  // flush wins over accept
  assign accept    = (state == S_IDLE) && req_valid && !flush;
  // a flush in the same cycle as the divider answer discards the result
  assign div_ret   = (state == S_DIV_WAIT) && div_out_valid && !flush;

  assign mul_src1 = req_src1;
  assign mul_src2 = req_src2;

  // multiplier op select from the presented request
  always_comb begin
    mul_op = 2'b00;
    case (kind)
      K_MULT:  mul_op = MD_MUL_SGN;
      K_MULTU: mul_op = MD_MUL_USGN;
      default: mul_op = 2'b00;
    endcase
  end

  // HI/LO write selection: divide retirement or an accepted MUL/MT op
  always_comb begin
    hi_we    = 1'b0;
    lo_we    = 1'b0;
    hi_wdata = mul_result[63:32];
    lo_wdata = mul_result[31:0];
    if (div_ret) begin
      hi_we    = 1'b1;
      lo_we    = 1'b1;
      hi_wdata = div_result[63:32];
      lo_wdata = div_result[31:0];
    end else if (accept) begin
      case (kind)
        K_MULT, K_MULTU: begin
          hi_we = 1'b1;
          lo_we = 1'b1;
        end
        K_MTHI: begin
          hi_we    = 1'b1;
          hi_wdata = req_src1;
        end
        K_MTLO: begin
          lo_we    = 1'b1;
          lo_wdata = req_src1;
        end
        default: begin
          hi_we = 1'b0;
          lo_we = 1'b0;
        end
      endcase
    end else begin
      hi_we = 1'b0;
      lo_we = 1'b0;
    end
  end

  // issue FSM with registered divider interface, done pulse and timeout
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= S_IDLE;
      done          <= 1'b0;
      div_in_valid  <= 1'b0;
      div_out_ready <= 1'b0;
      div_op        <= 2'b00;
      dividend      <= 32'h0;
      divisor       <= 32'h0;
      wait_cnt      <= 32'h0;
      div_err       <= 1'b0;
    end else begin
      done         <= hi_we | lo_we;
      div_in_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept && (kind == K_DIV || kind == K_DIVU)) begin
            state         <= S_DIV_WAIT;
            div_in_valid  <= 1'b1;
            div_out_ready <= 1'b1;
            div_op        <= (kind == K_DIVU) ? MD_MUL_USGN : MD_MUL_SGN;
            dividend      <= req_src1;
            divisor       <= req_src2;
            wait_cnt      <= 32'h0;
          end
        end
        S_DIV_WAIT: begin
          if (div_out_valid) begin
            state         <= S_IDLE;
            div_out_ready <= 1'b0;
          end else if (flush) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (div_out_valid) begin
            state         <= S_IDLE;
            div_out_ready <= 1'b0;
          end
        end
        default: begin
          state         <= S_IDLE;
          div_out_ready <= 1'b0;
        end
      endcase
      // saturating count of cycles spent waiting on the divider
      if (state != S_IDLE && wait_cnt != 32'hFFFF_FFFF) begin
        wait_cnt <= wait_cnt + 32'd1;
      end
      if (DIV_TIMEOUT != 0 && state != S_IDLE && (wait_cnt + 32'd1) == 32'(DIV_TIMEOUT)) begin
        div_err <= 1'b1;
      end
    end
  end

`ifdef MD_HILO_BYPASS_EN
  assign busy = (state != S_IDLE) && !div_out_valid;
`else
  assign busy = (state != S_IDLE) || done;
`endif

  md_hilo_reg u_hilo (
    .clk      (clk),
    .resetn   (resetn),
    .hi_we    (hi_we),
    .lo_we    (lo_we),
    .hi_wdata (hi_wdata),
    .lo_wdata (lo_wdata),
    .hi       (hi),
    .lo       (lo)
  );

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: self-checking bench for md_unit with a behavioural multiplier,
// a latency-programmable divider responder and a HI/LO reference model.
module tb_md_unit;
  import md_pkg::*;

  localparam int TMO = 16;
`ifdef MD_HILO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam logic [5:0] C_MULT  = 6'b000001;
  localparam logic [5:0] C_MULTU = 6'b000010;
  localparam logic [5:0] C_DIV   = 6'b000100;
  localparam logic [5:0] C_DIVU  = 6'b001000;
  localparam logic [5:0] C_MTHI  = 6'b010000;
  localparam logic [5:0] C_MTLO  = 6'b100000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [5:0]  req_op = 6'h0;
  logic [31:0] req_src1 = 32'h0;
  logic [31:0] req_src2 = 32'h0;
  logic        flush = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;
  logic [1:0]  mul_op;
  logic [31:0] mul_src1, mul_src2;
  logic [63:0] mul_result;
  logic [1:0]  div_op;
  logic [31:0] dividend, divisor;
  logic        div_in_valid;
  logic [63:0] div_result;
  logic        div_out_valid;
  logic        div_out_ready;
  logic        div_err;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_hi = 32'h0;
  logic [31:0] exp_lo = 32'h0;

  // divider responder state
  int   dv_lat = 10;
  int   dv_cnt;
  logic dv_busy;
  logic dv_respond = 1'b1;
  int   dv_launches = 0;

  always #5 clk = ~clk;

  md_unit #(.DIV_TIMEOUT(TMO)) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_src1(req_src1), .req_src2(req_src2), .flush(flush),
    .busy(busy), .done(done), .hi(hi), .lo(lo),
    .mul_op(mul_op), .mul_src1(mul_src1), .mul_src2(mul_src2), .mul_result(mul_result),
    .div_op(div_op), .dividend(dividend), .divisor(divisor), .div_in_valid(div_in_valid),
    .div_result(div_result), .div_out_valid(div_out_valid), .div_out_ready(div_out_ready),
    .div_err(div_err)
  );

  // reference arithmetic: 64-bit product
  function automatic logic [63:0] ref_mul(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint p;
    if (sgn) p = longint'(int'(a)) * longint'(int'(b));
    else     p = longint'({32'h0, a}) * longint'({32'h0, b});
    return p;
  endfunction

  // reference arithmetic: {remainder, quotient}; /0 gives quotient all-ones, remainder = dividend
  function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    int q, r;
    if (b == 32'h0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      if (b == 32'hFFFF_FFFF) return {32'h0, 32'h0 - a};
      q = int'(a) / int'(b);
      r = int'(a) % int'(b);
      return {32'(r), 32'(q)};
    end
    return {a % b, a / b};
  endfunction

  always_comb begin
    mul_result = 64'h0;
    if (mul_op == MD_MUL_SGN)       mul_result = ref_mul(1'b1, mul_src1, mul_src2);
    else if (mul_op == MD_MUL_USGN) mul_result = ref_mul(1'b0, mul_src1, mul_src2);
  end

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_out_valid <= 1'b0;
      dv_busy       <= 1'b0;
      dv_cnt        <= 0;
      div_result    <= 64'h0;
    end else if (div_in_valid) begin
      dv_launches <= dv_launches + 1;
      dv_busy     <= 1'b1;
      dv_cnt      <= dv_lat;
      div_result  <= ref_div(div_op == MD_MUL_SGN, dividend, divisor);
    end else if (div_out_valid && div_out_ready) begin
      div_out_valid <= 1'b0;
      dv_busy       <= 1'b0;
    end else if (dv_busy && !div_out_valid) begin
      if (dv_cnt > 1) dv_cnt <= dv_cnt - 1;
      else if (dv_respond) div_out_valid <= 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    req_valid = 1'b1;
    req_op    = op;
    req_src1  = a;
    req_src2  = b;
    step();
    req_valid = 1'b0;
    req_op    = 6'h0;
  endtask

  task automatic test_reset();
    repeat (3) step();
    checks++;
    if ({req_ready, busy, done, div_in_valid, div_out_ready, div_err, div_op} !== 8'b1000_0000 ||
        {hi, lo, dividend, divisor} !== 128'h0) begin
      errors++;
      $display("FAIL reset_state ctl got %b hi=%h lo=%h dvd=%h dvs=%h want ctl 10000000 and zeros",
               {req_ready, busy, done, div_in_valid, div_out_ready, div_err, div_op}, hi, lo, dividend, divisor);
    end
    resetn = 1'b1;
    step();
    checks++;
    if ({req_ready, busy, done} !== 3'b100) begin
      errors++;
      $display("FAIL reset_release got rdy/busy/done=%b want 100", {req_ready, busy, done});
    end
  endtask

  task automatic test_mul();
    logic [5:0]  op;
    logic [31:0] a, b;
    logic [63:0] p;
    logic        wrote;
    int          sel;
    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      b = $urandom;
      sel = $urandom_range(0, 4);
      case (sel)
        0: op = C_MULT;
        1: op = C_MULTU;
        2: op = C_MTHI;
        3: op = C_MTLO;
        default: begin
          op = 6'($urandom_range(0, 63));
          if ($onehot(op)) op = op | 6'b000011;
        end
      endcase
      if (i < 2) begin
        op = (i == 0) ? C_MULT : C_MULTU;
        a = 32'hFFFF_FFFE;
        b = 32'd3;
      end
      wrote = 1'b1;
      if (i == 0)           {exp_hi, exp_lo} = {32'hFFFF_FFFF, 32'hFFFF_FFFA};
      else if (i == 1)      {exp_hi, exp_lo} = {32'h0000_0002, 32'hFFFF_FFFA};
      else if (op == C_MULT)  {exp_hi, exp_lo} = ref_mul(1'b1, a, b);
      else if (op == C_MULTU) {exp_hi, exp_lo} = ref_mul(1'b0, a, b);
      else if (op == C_MTHI)  exp_hi = a;
      else if (op == C_MTLO)  exp_lo = a;
      else wrote = 1'b0;
      issue(op, a, b);
      checks++;
      if ({hi, lo} !== {exp_hi, exp_lo}) begin
        errors++;
        $display("FAIL mul_hilo i=%0d op=%b got %h_%h want %h_%h", i, op, hi, lo, exp_hi, exp_lo);
      end
      checks++;
      if ({done, busy, div_in_valid, req_ready} !== {wrote, wrote & ~BYP, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL mul_status i=%0d op=%b got done/busy/dinv/rdy=%b want %b", i, op,
                 {done, busy, div_in_valid, req_ready}, {wrote, wrote & ~BYP, 1'b0, 1'b1});
      end
      step();
      checks++;
      if ({done, busy} !== 2'b00) begin
        errors++;
        $display("FAIL mul_after i=%0d got done/busy=%b want 00", i, {done, busy});
      end
    end
  endtask

  task automatic test_div();
    logic [5:0]  op;
    logic [31:0] a, b;
    int          n, base;
    logic        bad;
    for (int i = 0; i < 8; i++) begin
      op = ($urandom_range(0, 1) == 0) ? C_DIV : C_DIVU;
      a  = $urandom;
      b  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : 32'($urandom);
      if (i == 0) begin op = C_DIV; a = 32'hFFFF_FFF9; b = 32'd2; end
      if (i == 1) b = 32'h0;
      if (i == 0) {exp_hi, exp_lo} = {32'hFFFF_FFFF, 32'hFFFF_FFFD};
      else        {exp_hi, exp_lo} = ref_div(op == C_DIV, a, b);
      base = dv_launches;
      issue(op, a, b);
      checks++;
      if ({div_in_valid, div_op, dividend, divisor} !==
          {1'b1, (op == C_DIV) ? 2'b01 : 2'b10, a, b}) begin
        errors++;
        $display("FAIL div_launch i=%0d got v=%b op=%b %h/%h want 1 %b %h/%h", i, div_in_valid,
                 div_op, dividend, divisor, (op == C_DIV) ? 2'b01 : 2'b10, a, b);
      end
      n = 0;
      bad = 1'b0;
      while (done !== 1'b1 && n < 200) begin
        if (busy !== (BYP ? ~div_out_valid : 1'b1) || req_ready !== 1'b0) bad = 1'b1;
        step();
        n++;
      end
      checks++;
      if (n >= 200 || bad) begin
        errors++;
        $display("FAIL div_wait i=%0d got cycles=%0d busy_bad=%b want done within 200 and busy held", i, n, bad);
      end
      checks++;
      if ({hi, lo} !== {exp_hi, exp_lo} || dv_launches - base !== 1) begin
        errors++;
        $display("FAIL div_result i=%0d got %h_%h launches=%0d want %h_%h launches=1", i, hi, lo,
                 dv_launches - base, exp_hi, exp_lo);
      end
      checks++;
      if ({busy, req_ready} !== {~BYP, 1'b1}) begin
        errors++;
        $display("FAIL div_done_busy i=%0d got busy/rdy=%b want %b", i, {busy, req_ready}, {~BYP, 1'b1});
      end
      step();
      checks++;
      if ({busy, done} !== 2'b00) begin
        errors++;
        $display("FAIL div_after i=%0d got busy/done=%b want 00", i, {busy, done});
      end
    end
  endtask

  task automatic test_back_to_back();
    int   n;
    logic bad;
    logic [31:0] hi0;
    hi0 = exp_hi;
    req_valid = 1'b1;
    req_op    = C_DIVU;
    req_src1  = 32'd100;
    req_src2  = 32'd7;
    step();
    req_op   = C_MTHI;
    req_src1 = 32'd5;
    n = 0;
    bad = 1'b0;
    while (done !== 1'b1 && n < 200) begin
      if (req_ready !== 1'b0 || hi !== hi0) bad = 1'b1;
      step();
      n++;
    end
    checks++;
    if (n >= 200 || bad || {hi, lo} !== {32'd2, 32'd14} || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_div got cycles=%0d early_accept=%b hi/lo=%h_%h rdy=%b want hi/lo=2_14 rdy=1",
               n, bad, hi, lo, req_ready);
    end
    step();
    req_valid = 1'b0;
    exp_hi = 32'd5;
    exp_lo = 32'd14;
    checks++;
    if ({hi, lo, done} !== {exp_hi, exp_lo, 1'b1}) begin
      errors++;
      $display("FAIL b2b_mthi got hi/lo=%h_%h done=%b want 5_e done=1", hi, lo, done);
    end
    step();
  endtask

  task automatic test_flush_drain();
    int   n;
    logic bad;
    logic [31:0] a, b;
    issue(C_MTHI, 32'hAA, 32'h0);
    issue(C_MTLO, 32'hBB, 32'h0);
    exp_hi = 32'hAA;
    exp_lo = 32'hBB;
    step();
    issue(C_DIV, $urandom, 32'd3);
    step();
    step();
    flush = 1'b1;
    step();
    step();
    flush = 1'b0;
    n = 0;
    bad = 1'b0;
    while (div_out_ready === 1'b1 && n < 200) begin
      if (done !== 1'b0 || busy !== (BYP ? ~div_out_valid : 1'b1)) bad = 1'b1;
      step();
      n++;
    end
    checks++;
    if (n >= 200 || bad || done !== 1'b0 || dv_busy !== 1'b0) begin
      errors++;
      $display("FAIL drain got cycles=%0d bad=%b done=%b divider_busy=%b want drained, no done",
               n, bad, done, dv_busy);
    end
    checks++;
    if ({hi, lo} !== {exp_hi, exp_lo}) begin
      errors++;
      $display("FAIL drain_hilo got %h_%h want %h_%h", hi, lo, exp_hi, exp_lo);
    end
    a = $urandom;
    b = $urandom;
    {exp_hi, exp_lo} = ref_mul(1'b1, a, b);
    issue(C_MULT, a, b);
    checks++;
    if ({hi, lo, done} !== {exp_hi, exp_lo, 1'b1}) begin
      errors++;
      $display("FAIL drain_mult got %h_%h done=%b want %h_%h done=1", hi, lo, done, exp_hi, exp_lo);
    end
    step();
  endtask

  task automatic test_flush_coincident();
    int n;
    issue(C_DIVU, $urandom, 32'd9);
    n = 0;
    while (div_out_valid !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if (n >= 200 || {req_ready, div_out_ready, done, busy} !== 4'b1000 || {hi, lo} !== {exp_hi, exp_lo}) begin
      errors++;
      $display("FAIL flush_coincident got cycles=%0d rdy/dordy/done/busy=%b hi/lo=%h_%h want 1000 %h_%h",
               n, {req_ready, div_out_ready, done, busy}, hi, lo, exp_hi, exp_lo);
    end
    step();
    checks++;
    if ({div_out_valid, dv_busy} !== 2'b00) begin
      errors++;
      $display("FAIL flush_consumed got dout_valid/divider_busy=%b want 00", {div_out_valid, dv_busy});
    end
    flush = 1'b1;
    issue(C_MTLO, ~exp_lo, 32'h0);
    flush = 1'b0;
    checks++;
    if ({lo, done} !== {exp_lo, 1'b0}) begin
      errors++;
      $display("FAIL flush_mtlo got lo=%h done=%b want lo=%h done=0", lo, done, exp_lo);
    end
    step();
  endtask

  task automatic test_timeout();
    logic early;
    dv_respond = 1'b0;
    issue(C_DIV, 32'd50, 32'd5);
    early = 1'b0;
    for (int i = 0; i < TMO - 1; i++) begin
      step();
      if (div_err !== 1'b0) early = 1'b1;
    end
    checks++;
    if (early) begin
      errors++;
      $display("FAIL timeout_early got div_err=1 before %0d cycles want 0", TMO);
    end
    step();
    checks++;
    if ({div_err, busy, req_ready} !== 3'b110) begin
      errors++;
      $display("FAIL timeout_flag got err/busy/rdy=%b want 110", {div_err, busy, req_ready});
    end
    #2;
    resetn = 1'b0;
    #1;
    exp_hi = 32'h0;
    exp_lo = 32'h0;
    checks++;
    if ({req_ready, busy, done, div_in_valid, div_out_ready, div_err, div_op} !== 8'b1000_0000 ||
        {hi, lo, dividend, divisor} !== 128'h0) begin
      errors++;
      $display("FAIL async_reset ctl got %b hi=%h lo=%h dvd=%h dvs=%h want ctl 10000000 and zeros",
               {req_ready, busy, done, div_in_valid, div_out_ready, div_err, div_op}, hi, lo, dividend, divisor);
    end
    step();
    resetn = 1'b1;
    dv_respond = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_back_to_back();
    test_flush_drain();
    test_flush_coincident();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
